// File: rtl/multicycle_control_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// It holds the instruction register, the registered immediate selector, the
// memory wait counter and the retired-instruction counter. It drives the
// datapath enables for one instruction at a time.
module multicycle_control_fsm #(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        Instr,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic [2:0]         imm_select,
  output logic [31:0]        ir_out,
  output logic               alu_src,
  output logic [1:0]         alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               pc_write,
  output logic               pc_src,
  output logic               busy,
  output logic               illegal,
  output logic               mem_timeout,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              stop_pend_q;
  logic              retire;

  // Immediate format implied by an opcode; unsupported and OP give 000.
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_OPIMM: imm_of = 3'b111;
      OPC_STORE:           imm_of = 3'b001;
      OPC_BRANCH:          imm_of = 3'b011;
      default:             imm_of = 3'b000;
    endcase
  endfunction

  // Instruction class, decoded from the latched IR only.
  logic is_load, is_store, is_branch, is_opimm, is_op, is_legal;
  always_comb begin
    is_load   = (ir_out[6:0] == OPC_LOAD);
    is_store  = (ir_out[6:0] == OPC_STORE);
    is_branch = (ir_out[6:0] == OPC_BRANCH);
    is_opimm  = (ir_out[6:0] == OPC_OPIMM);
    is_op     = (ir_out[6:0] == OPC_OP);
    is_legal  = is_load | is_store | is_branch | is_opimm | is_op;
  end

  // A finished instruction returns to IDLE if stop is seen now or was seen
  // earlier in the instruction; otherwise it fetches the next one.
  state_t boundary_next;
  always_comb begin
    boundary_next = (stop || stop_pend_q) ? S_IDLE : S_FETCH;
  end

  // Next state plus all control outputs. Every output is 0 by default, so
  // IDLE (and therefore reset) drives everything low.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    instr_ready = 1'b0;
    alu_src     = 1'b0;
    alu_op      = 2'b00;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!is_legal) begin
          // Skip the bad word: advance PC, do not count it as retired.
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_d  = boundary_next;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_src = is_load | is_store | is_opimm;
        alu_op  = is_branch ? 2'b01 : ((is_load | is_store) ? 2'b00 : 2'b10);
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
          retire   = 1'b1;
          state_d  = boundary_next;
        end else if (is_load || is_store) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        mem_read  = is_load;
        mem_write = is_store;
        // mem_ready is checked first, so it wins over a timeout in the same cycle.
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = boundary_next;
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_timeout = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = boundary_next;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Instruction register, loaded on the fetch handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                ir_out <= '0;
    else if (state_q == S_FETCH && instr_valid) ir_out <= Instr;
  end

  // imm_select is loaded with the IR. It is then valid from DECODE and held
  // until the instruction leaves. It is cleared for IDLE and FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      imm_select <= 3'b000;
    else if (state_q == S_FETCH && instr_valid)
      imm_select <= imm_of(Instr[6:0]);
    else if (state_d == S_IDLE || state_d == S_FETCH)
      imm_select <= 3'b000;
  end

  // Memory wait counter: cleared on the way into MEMORY, counts cycles without mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                wait_q <= '0;
    else if (state_q == S_EXECUTE)            wait_q <= '0;
    else if (state_q == S_MEMORY && !mem_ready) wait_q <= wait_q + 1'b1;
  end

  // Remembers a stop request until the next instruction boundary; IDLE drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          stop_pend_q <= 1'b0;
    else if (state_d == S_IDLE)         stop_pend_q <= 1'b0;
    else if (state_q != S_IDLE && stop) stop_pend_q <= 1'b1;
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm. Each instruction is described
// at transaction level (opcode, fetch stall, memory stall, branch outcome,
// stop request). The expected per-cycle control trace is built from the
// instruction rules. A second instance with a 2-bit counter checks wrap.
module tb_multicycle_control_fsm;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset, start, stop, instr_valid, branch_taken, mem_ready;
  logic [31:0] Instr;

  logic        instr_ready, alu_src, mem_read, mem_write, reg_write, mem_to_reg;
  logic        pc_write, pc_src, busy, illegal, mem_timeout;
  logic [2:0]  imm_select;
  logic [1:0]  alu_op;
  logic [31:0] ir_out;
  logic [15:0] instr_count;

  logic        instr_ready2, alu_src2, mem_read2, mem_write2, reg_write2, mem_to_reg2;
  logic        pc_write2, pc_src2, busy2, illegal2, mem_timeout2;
  logic [2:0]  imm_select2;
  logic [1:0]  alu_op2;
  logic [31:0] ir_out2;
  logic [1:0]  instr_count2;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_count = '0;

  multicycle_control_fsm #(.COUNT_W(16), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .Instr(Instr),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .imm_select(imm_select), .ir_out(ir_out), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src), .busy(busy),
    .illegal(illegal), .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  multicycle_control_fsm #(.COUNT_W(2), .MEM_TIMEOUT(TMO)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .instr_valid(instr_valid), .instr_ready(instr_ready2), .Instr(Instr),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .imm_select(imm_select2), .ir_out(ir_out2), .alu_src(alu_src2), .alu_op(alu_op2),
    .mem_read(mem_read2), .mem_write(mem_write2), .reg_write(reg_write2),
    .mem_to_reg(mem_to_reg2), .pc_write(pc_write2), .pc_src(pc_src2), .busy(busy2),
    .illegal(illegal2), .mem_timeout(mem_timeout2), .instr_count(instr_count2)
  );

  always #5 clk = ~clk;

  logic [15:0] outvec, outvec2;
  assign outvec  = {instr_ready, imm_select, alu_src, alu_op, mem_read, mem_write,
                    reg_write, mem_to_reg, pc_write, pc_src, busy, illegal, mem_timeout};
  assign outvec2 = {instr_ready2, imm_select2, alu_src2, alu_op2, mem_read2, mem_write2,
                    reg_write2, mem_to_reg2, pc_write2, pc_src2, busy2, illegal2, mem_timeout2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ev(input logic rdy, input logic [2:0] imm, input logic as,
                                     input logic [1:0] aop, input logic mr, input logic mw,
                                     input logic rw, input logic m2r, input logic pw,
                                     input logic ps, input logic bsy, input logic ill,
                                     input logic tmo);
    return {rdy, imm, as, aop, mr, mw, rw, m2r, pw, ps, bsy, ill, tmo};
  endfunction

  // Inputs are already driven (just after a negedge). Check the control word,
  // then move to the next negedge.
  task automatic step(input string tag, input logic [15:0] e);
    #2;
    chk(tag, {16'h0, outvec}, {16'h0, e});
    chk({tag, "_w2"}, {16'h0, outvec2}, {16'h0, e});
    @(negedge clk);
  endtask

  task automatic check_count();
    chk("cnt", {16'h0, instr_count}, {16'h0, exp_count});
    chk("cnt_w2", {30'h0, instr_count2}, {30'h0, exp_count[1:0]});
  endtask

  // One IDLE cycle with stop as noise, then one IDLE cycle with start (stop may also be high).
  task automatic restart();
    instr_valid = 1'b0; start = 1'b0; stop = 1'($urandom);
    step("idle", 16'h0);
    start = 1'b1; stop = 1'($urandom);
    step("idle_start", 16'h0);
    start = 1'b0; stop = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle to its last cycle.
  task automatic run_instr(input logic [31:0] w, input int fwait, input int mwait,
                           input logic taken, input logic stp);
    logic [6:0] op;
    logic [2:0] im;
    logic ld, st, br, oi, o, legal, ret, tmo_hit;
    op = w[6:0];
    ld = (op == 7'b0000011); st = (op == 7'b0100011); br = (op == 7'b1100011);
    oi = (op == 7'b0010011); o  = (op == 7'b0110011);
    legal = ld | st | br | oi | o;
    im = (ld | oi) ? 3'b111 : st ? 3'b001 : br ? 3'b011 : 3'b000;
    ret = 1'b0; tmo_hit = 1'b0;
    stop = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < fwait; i++) begin
      instr_valid = 1'b0; Instr = $urandom; start = 1'($urandom);
      step("fetch_wait", ev(1,3'b0,0,2'b0,0,0,0,0,0,0,1,0,0));
    end
    instr_valid = 1'b1; Instr = w; start = 1'($urandom);
    step("fetch", ev(1,3'b0,0,2'b0,0,0,0,0,0,0,1,0,0));
    instr_valid = 1'($urandom); Instr = $urandom; stop = stp;
    if (!legal) begin
      step("decode_ill", ev(0,3'b0,0,2'b0,0,0,0,0,1,0,1,1,0));
      chk("ir", ir_out, w);
    end else begin
      step("decode", ev(0,im,0,2'b0,0,0,0,0,0,0,1,0,0));
      chk("ir", ir_out, w);
      stop = 1'b0; branch_taken = taken;
      if (br) begin
        step("exec_br", ev(0,im,0,2'b01,0,0,0,0,1,taken,1,0,0));
        ret = 1'b1;
      end else begin
        step("exec", ev(0,im,ld|st|oi,(ld|st) ? 2'b00 : 2'b10,0,0,0,0,0,0,1,0,0));
        branch_taken = 1'($urandom);
        if (ld || st) begin
          for (int k = 0; k <= TMO; k++) begin
            mem_ready = (k == mwait);
            if (mem_ready) begin
              if (st) begin
                step("mem_st_done", ev(0,im,0,2'b0,0,1,0,0,1,0,1,0,0));
                ret = 1'b1;
              end else begin
                step("mem_ld_done", ev(0,im,0,2'b0,1,0,0,0,0,0,1,0,0));
              end
              break;
            end else if (k == TMO - 1) begin
              step("mem_tmo", ev(0,im,0,2'b0,ld,st,0,0,0,0,1,0,1));
              tmo_hit = 1'b1;
              break;
            end else begin
              step("mem_wait", ev(0,im,0,2'b0,ld,st,0,0,0,0,1,0,0));
            end
          end
          mem_ready = 1'b0;
        end
        if (!st && !tmo_hit) begin
          step("wb", ev(0,im,0,2'b0,0,0,1,ld,1,0,1,0,0));
          ret = 1'b1;
        end
      end
    end
    if (ret) exp_count = exp_count + 16'd1;
    stop = 1'b0;
    check_count();
    if (stp || tmo_hit) restart();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    int          r;
    w = $urandom;
    r = $urandom_range(0, 5);
    case (r)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b1100011;
      3: op = 7'b0010011;
      4: op = 7'b0110011;
      default: begin
        op = 7'($urandom);
        if (op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011 ||
            op == 7'b0010011 || op == 7'b0110011) op = 7'b1111111;
      end
    endcase
    w[6:0] = op;
    return w;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; instr_valid = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b0; Instr = '0;
    #12;
    chk("rst_ctl", {16'h0, outvec}, 32'h0);
    chk("rst_ir", ir_out, 32'h0);
    check_count();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    step("idle_start", 16'h0);
    start = 1'b0;

    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);   // OP-IMM
    run_instr(32'h00112223, 1, 2, 1'b0, 1'b0);   // STORE, two-cycle memory stall
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0);   // BRANCH taken
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0);   // BRANCH not taken
    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);   // illegal opcode
    run_instr(32'h00012083, 0, 14, 1'b0, 1'b0);  // LOAD, ready in the last allowed cycle
    run_instr(32'h00012083, 0, 99, 1'b0, 1'b0);  // LOAD timeout
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b1);   // OP with stop
    run_instr(32'h0000007F, 2, 0, 1'b0, 1'b1);   // illegal with stop

    for (int n = 0; n < 300; n++)
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 17),
                1'($urandom), ($urandom_range(0, 9) == 0));

    // Asynchronous reset while a load waits in MEMORY.
    instr_valid = 1'b1; Instr = 32'h00012083;
    step("rs_fetch", ev(1,3'b0,0,2'b0,0,0,0,0,0,0,1,0,0));
    instr_valid = 1'b0;
    step("rs_decode", ev(0,3'b111,0,2'b0,0,0,0,0,0,0,1,0,0));
    step("rs_exec", ev(0,3'b111,1,2'b00,0,0,0,0,0,0,1,0,0));
    step("rs_mem", ev(0,3'b111,0,2'b0,1,0,0,0,0,0,1,0,0));
    #1 reset = 1'b1;
    #1;
    chk("arst_ctl", {16'h0, outvec}, 32'h0);
    chk("arst_ctl_w2", {16'h0, outvec2}, 32'h0);
    chk("arst_ir", ir_out, 32'h0);
    exp_count = '0;
    check_count();
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    step("idle_start", 16'h0);
    start = 1'b0;
    // Four retires: 2-bit counter goes 1,2,3,0.
    for (int n = 0; n < 4; n++) run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Safety bound on total runtime.
  initial begin
    #900000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
